// File: rtl/keypad_pkg.sv
// keypad_pkg: shared FSM states, matrix geometry and key encodings for the keypad scanner.
package keypad_pkg;
  localparam int ROW_N = 4;
  localparam int COL_N = 4;
  localparam logic [4:0] KEY_NONE = 5'b1_0000;
  localparam logic [ROW_N-1:0] ROW_RST = 4'b1110;
  typedef enum logic [1:0] {ST_SCAN, ST_DEBOUNCE, ST_PRESSED, ST_RELEASE} state_t;
  // {hit, col}: hit only when exactly one column is pulled low
  function automatic logic [2:0] col_decode(input logic [COL_N-1:0] c);
    return c == 4'b1110 ? 3'b100 : c == 4'b1101 ? 3'b101 :
           c == 4'b1011 ? 3'b110 : c == 4'b0111 ? 3'b111 : 3'b000;
  endfunction
endpackage

// File: rtl/keypad_tick_gen.sv
// keypad_tick_gen: free-running divider emitting a one-cycle tick every DIV clocks.
module keypad_tick_gen #(
  parameter int DIV = 50_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);
  localparam int W = DIV > 1 ? $clog2(DIV) : 1;
  localparam logic [W-1:0] TC = W'(DIV - 1);
  logic [W-1:0] cnt;
  assign tick = cnt == TC;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 active-low matrix scan with debounce, one key code per press.
// Optional auto-repeat while held is enabled by defining KEYPAD_REPEAT_EN.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int CLK_HZ        = 50_000_000,
  parameter int SCAN_HZ       = 1_000,
  parameter int DEBOUNCE_TK   = 20,
  parameter int REPEAT_DLY_TK = 500,
  parameter int REPEAT_PER_TK = 100
) (
  input  logic             clk_50mhz,
  input  logic             rst,
  input  logic [COL_N-1:0] col_in,
  output logic [ROW_N-1:0] row_out,
  output logic [3:0]       key_code,
  output logic             key_valid,
  output logic             key_held
);
  localparam int CW = $clog2(DEBOUNCE_TK + 2);
  logic tick, scan_done, seen, present, valid_n, held_n;
  logic [COL_N-1:0] col_m, col_s;
  logic [1:0] row;
  logic [2:0] dec;
  logic [4:0] acc, res;
  logic [3:0] cand, cand_n, code_n;
  logic [CW-1:0] cnt, cnt_n, cnt_inc;
  state_t st, st_n;
  keypad_tick_gen #(.DIV(CLK_HZ / SCAN_HZ)) u_tick (.clk(clk_50mhz), .rst_n(rst), .tick(tick));
  // acc carries the first hit of the scan in progress; seen tracks whether cand appeared anywhere
  assign dec = col_decode(col_s);
  assign scan_done = tick && row == 2'd3;
  assign res = !acc[4] ? acc : dec[2] ? {1'b0, row, dec[1:0]} : KEY_NONE;
  assign present = seen || (dec[2] && {row, dec[1:0]} == cand);
  assign cnt_inc = cnt + 1'b1;
`ifdef KEYPAD_REPEAT_EN
  localparam int DLY_SC = REPEAT_DLY_TK / ROW_N;
  localparam int PER_SC = REPEAT_PER_TK / ROW_N;
  localparam int RW = $clog2(DLY_SC + PER_SC + 2);
  logic [RW-1:0] rpt, rpt_n, rpt_inc;
  logic rpt_on, rpt_on_n;
  assign rpt_inc = rpt + 1'b1;
  always_ff @(posedge clk_50mhz or negedge rst)
    if (!rst) begin
      rpt <= '0;
      rpt_on <= 1'b0;
    end else begin
      rpt <= rpt_n;
      rpt_on <= rpt_on_n;
    end
`endif
  always_ff @(posedge clk_50mhz or negedge rst)
    if (!rst) begin
      col_m <= '1;
      col_s <= '1;
      row_out <= ROW_RST;
      row <= '0;
      acc <= KEY_NONE;
      seen <= 1'b0;
      st <= ST_SCAN;
      cand <= '0;
      cnt <= '0;
      key_code <= '0;
      key_valid <= 1'b0;
      key_held <= 1'b0;
    end else begin
      col_m <= col_in;
      col_s <= col_m;
      st <= st_n;
      cand <= cand_n;
      cnt <= cnt_n;
      key_code <= code_n;
      key_valid <= valid_n;
      key_held <= held_n;
      if (tick) begin
        row_out <= {row_out[ROW_N-2:0], row_out[ROW_N-1]};
        row <= row + 1'b1;
        acc <= scan_done ? KEY_NONE : res;
        seen <= !scan_done && present;
      end
    end
  always_comb begin
    st_n = st;
    cand_n = cand;
    cnt_n = cnt;
    code_n = key_code;
    held_n = key_held;
    valid_n = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rpt_n = st == ST_PRESSED ? rpt : '0;
    rpt_on_n = st == ST_PRESSED && rpt_on;
`endif
    if (scan_done)
      case (st)
        ST_SCAN:
          if (!res[4]) begin
            cand_n = res[3:0];
            cnt_n = CW'(1);
            st_n = ST_DEBOUNCE;
          end
        ST_DEBOUNCE:
          if (res == {1'b0, cand}) begin
            cnt_n = cnt_inc;
            if (cnt_inc >= CW'(DEBOUNCE_TK)) begin
              cnt_n = '0;
              code_n = cand;
              valid_n = 1'b1;
              held_n = 1'b1;
              st_n = ST_PRESSED;
            end
          end else begin
            cnt_n = '0;
            st_n = ST_SCAN;
          end
        ST_PRESSED: begin
          cnt_n = present ? '0 : CW'(1);
          st_n = present ? ST_PRESSED : ST_RELEASE;
`ifdef KEYPAD_REPEAT_EN
          if (present) begin
            rpt_n = rpt_inc;
            if (rpt_inc >= (rpt_on ? RW'(PER_SC) : RW'(DLY_SC))) begin
              rpt_n = '0;
              rpt_on_n = 1'b1;
              valid_n = 1'b1;
            end
          end
`endif
        end
        ST_RELEASE:
          if (present) begin
            cnt_n = '0;
            st_n = ST_PRESSED;
          end else begin
            cnt_n = cnt_inc;
            if (cnt_inc >= CW'(DEBOUNCE_TK)) begin
              cnt_n = '0;
              held_n = 1'b0;
              st_n = ST_SCAN;
            end
          end
        default: st_n = ST_SCAN;
      endcase
  end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: scoreboard bench for keypad_scanner with a shorting keypad matrix model.
module tb_keypad_scanner;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [3:0] col_in, row_out, key_code;
  logic key_valid, key_held;
  logic [15:0] keys = '0;
  logic [3:0] exp_q[$];
  int ptimes[$];
  int n_vec = 0, n_err = 0, cyc = 0, pulses = 0, p0 = 0;
  logic prev_valid = 1'b0, held_prev = 1'b0;
  logic [3:0] last_code = '0;
  logic [4:0] exp_code;

  keypad_scanner #(
    .CLK_HZ(1000), .SCAN_HZ(100), .DEBOUNCE_TK(3), .REPEAT_DLY_TK(8), .REPEAT_PER_TK(4)
  ) dut (
    .clk_50mhz(clk), .rst(rst), .col_in(col_in), .row_out(row_out),
    .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // a closed key shorts its row line onto its column line
  always_comb begin
    col_in = '1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row_out[r] && keys[r*4+c]) col_in[c] = 1'b0;
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, wanted %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst && key_valid) begin
      ptimes.push_back(cyc);
      check("valid_one_cycle", 16'(prev_valid), 16'h0);
`ifdef KEYPAD_REPEAT_EN
      if (held_prev) check("repeat_code", 16'(key_code), 16'(last_code));
      else
`endif
      begin
        pulses++;
        exp_code = exp_q.size() != 0 ? {1'b0, exp_q.pop_front()} : 5'h10;
        check("key_code", 16'(key_code), 16'(exp_code));
        last_code = key_code;
      end
    end
    prev_valid = rst && key_valid;
    held_prev = rst && key_held;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic release_all();
    keys = '0;
    wait_cyc(240);
    check("release_held", 16'(key_held), 16'h0);
  endtask

  initial begin
    wait_cyc(3);
    check("rst_row", 16'(row_out), 16'hE);
    check("rst_code", 16'(key_code), 16'h0);
    check("rst_valid", 16'(key_valid), 16'h0);
    check("rst_held", 16'(key_held), 16'h0);
    @(negedge clk) rst = 1'b1;
    // steady press of row2/col1
    p0 = pulses;
    @(negedge clk) keys[9] = 1'b1;
    exp_q.push_back(4'h9);
    wait_cyc(80);
    check("t2_held_early", 16'(key_held), 16'h0);
    wait_cyc(160);
    check("t2_held", 16'(key_held), 16'h1);
    check("t2_code", 16'(key_code), 16'h9);
    check("t2_pulses", 16'(pulses - p0), 16'h1);
    check("t2_sb_empty", 16'(exp_q.size()), 16'h0);
    // asynchronous reset mid-scan while the key is held
    wait_cyc(17);
    #3 rst = 1'b0;
    #1;
    check("t1_row", 16'(row_out), 16'hE);
    check("t1_code", 16'(key_code), 16'h0);
    check("t1_valid", 16'(key_valid), 16'h0);
    check("t1_held", 16'(key_held), 16'h0);
    keys = '0;
    wait_cyc(3);
    @(negedge clk) rst = 1'b1;
    // bouncing contact settles to a steady press
    p0 = pulses;
    exp_q.push_back(4'h9);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk) keys[9] = ~keys[9];
      repeat (9) @(posedge clk);
    end
    @(negedge clk) keys[9] = 1'b1;
    wait_cyc(240);
    check("t3_pulses", 16'(pulses - p0), 16'h1);
    check("t3_code", 16'(key_code), 16'h9);
    check("t3_held", 16'(key_held), 16'h1);
    check("t3_sb_empty", 16'(exp_q.size()), 16'h0);
    release_all();
    // ghost: two columns on one row never register
    p0 = pulses;
    @(negedge clk) begin keys[4] = 1'b1; keys[7] = 1'b1; end
    for (int i = 0; i < 24; i++) begin
      wait_cyc(10);
      check("t4_one_cold", 16'($countones(~row_out)), 16'h1);
    end
    check("t4_pulses", 16'(pulses - p0), 16'h0);
    check("t4_held", 16'(key_held), 16'h0);
    release_all();
    // rollover: second key waits for the first to be released
    p0 = pulses;
    exp_q.push_back(4'h5);
    @(negedge clk) keys[5] = 1'b1;
    wait_cyc(240);
    check("t5_held5", 16'(key_held), 16'h1);
    check("t5_code5", 16'(key_code), 16'h5);
    @(negedge clk) keys[10] = 1'b1;
    wait_cyc(240);
    check("t5_ignored", 16'(pulses - p0), 16'h1);
    check("t5_code_hold", 16'(key_code), 16'h5);
    exp_q.push_back(4'hA);
    @(negedge clk) keys[5] = 1'b0;
    repeat (80) @(posedge clk);
    #1 check("t5_held_still", 16'(key_held), 16'h1);
    repeat (119) @(posedge clk);
    #1 check("t5_held_fell", 16'(key_held), 16'h0);
    check("t5_a_pending", 16'(exp_q.size()), 16'h1);
    wait_cyc(200);
    check("t5_codeA", 16'(key_code), 16'hA);
    check("t5_heldA", 16'(key_held), 16'h1);
    check("t5_pulses", 16'(pulses - p0), 16'h2);
    release_all();
`ifdef KEYPAD_REPEAT_EN
    // auto-repeat: accept, +2 scans, then every scan
    ptimes.delete();
    exp_q.push_back(4'h3);
    @(negedge clk) keys[3] = 1'b1;
    for (int i = 0; i < 1000 && ptimes.size() < 4; i++) @(posedge clk);
    #1 check("t6_pulse_count", 16'(ptimes.size() >= 4), 16'h1);
    if (ptimes.size() >= 4) begin
      check("t6_first_gap", 16'(ptimes[1] - ptimes[0]), 16'd80);
      check("t6_gap2", 16'(ptimes[2] - ptimes[1]), 16'd40);
      check("t6_gap3", 16'(ptimes[3] - ptimes[2]), 16'd40);
    end
    check("t6_code", 16'(key_code), 16'h3);
    release_all();
`endif
    check("final_sb_empty", 16'(exp_q.size()), 16'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
